medication_reminder: RTL and testbench
======================================

// Module: medication_reminder
// PURPOSE
//  Programmable medication-dose reminder, packaged as a TinyTapeout user tile.
//  A prescaled tick drives a countdown of key_in-programmed length. At zero the block raises an alarm.
//  The alarm stays up until the user acknowledges the dose or an alert timeout logs a missed dose.
//  Taken/missed counts and the live countdown are exposed on the output pins.
// PARAMETERS
//  TICK_DIV       1000  clock cycles per tick (1 s on silicon; small values in sim)
//  ALERT_TIMEOUT  16    ticks in ALERT without ack before a dose counts as missed
//  SNOOZE_TICKS   4     ticks alarm is silenced by snooze (SNOOZE_EN only)
// PORTS
//  clk      in   1  single clock; all state on rising edge
//  rst_n    in   1  asynchronous active-low reset
//  ena      in   1  tile enable; low = freeze all state (prescaler included)
//  ui_in    in   8  [0] load, [1] ack, [2] snooze, [3] stop; [7:4] unused
//  key_in   in   8  dose interval in ticks, sampled on load
//  uio_in   in   8  unused
//  uo_out   out  8  [0] alarm, [1] buzzer, [2] counting, [3] missed_any, [7:4] taken_cnt
//  uio_out  out  8  remaining[7:0] (live countdown)
//  uio_oe   out  8  constant 8'hFF
// BEHAVIOUR
//  - Reset: state=IDLE; interval, remaining, prescaler, alert_cnt, taken_cnt, missed_cnt = 0.
//    Edge-detect flops = 0. uo_out=0, uio_out=0, uio_oe=8'hFF.
//  - ui_in[3:0] are rising-edge detected against registered copies; only active while ena=1.
//  - Tick: prescaler counts 0..TICK_DIV-1 while state != IDLE. tick is a 1-cycle pulse at
//    TICK_DIV-1, then the prescaler wraps to 0. Prescaler clears on load and on stop.
//  - Priority for same-cycle events: stop > load > ack > snooze > tick.
//  - stop (any state): -> IDLE, remaining=0. Counters are kept.
//  - load (any state): key_in==0 is ignored. Otherwise interval=remaining=key_in, -> COUNT.
//  - COUNT: each tick does remaining-1. A tick at remaining==1 -> ALERT, remaining=0, alert_cnt=0.
//  - ALERT: alarm=1; alert_cnt++ per tick.
//    ack -> taken_cnt++ (saturate 15), remaining=interval, -> COUNT.
//    A tick making alert_cnt==ALERT_TIMEOUT -> missed_cnt++ (saturate 15), remaining=interval, -> COUNT.
//  - ack/snooze outside ALERT are ignored.
//  - counting = (state==COUNT). missed_any = (missed_cnt!=0); cleared only by reset.
//  - buzzer = alarm & blink; blink is a flop toggled on each tick while in ALERT, reset 0.
//  - All outputs are registered or pure decode of registers; 1-cycle latency from input edge.
//  - remaining is 8 bits and never underflows (holds at 0 in ALERT/IDLE).
// CONFIGURATION
//  - MED_REMINDER_SNOOZE_EN defined:
//    snooze in ALERT -> SNOOZE state: alarm=0, snooze_cnt=0.
//    After SNOOZE_TICKS ticks -> ALERT with alert_cnt=0.
//    In SNOOZE, ack behaves as in ALERT; stop and load behave as in any state.
//  - Not defined: the SNOOZE state is absent and ui_in[2] is ignored.
// STRUCTURE
//  - medication_reminder_pkg: state encoding IDLE=0, COUNT=1, ALERT=2, SNOOZE=3;
//    uo_out bit index constants; CNT_MAX=4'hF.
//  - Sub-module rm_tick_gen: prescaler with en/clr inputs and tick output.
//    Top holds edge detect, FSM, counters and output mapping.
// TESTING  (TICK_DIV=4, ALERT_TIMEOUT=3, SNOOZE_TICKS=2)
//  - Reset, ena=1:
//    -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
//  - key_in=3, pulse load:
//    -> counting=1, uio_out=3 then 2,1 at 4-cycle steps.
//    -> alarm=1 on the 3rd tick, uio_out=0.
//  - In ALERT, pulse ack:
//    -> alarm=0, uo_out[7:4]=1, uio_out=3, counting=1.
//  - In ALERT, no ack for 3 ticks:
//    -> missed_any=1, countdown restarts at 3, taken count unchanged.
//  - key_in=0 load from IDLE: stays IDLE. ena=0 mid-count: uio_out frozen.
//    Stop+ack in the same cycle: IDLE, taken count unchanged.
//  - SNOOZE_EN: snooze in ALERT -> alarm=0 for 2 ticks, then alarm=1.
//    Without SNOOZE_EN: alarm unchanged.

Source files
------------

// File: rtl/medication_reminder_pkg.sv
// Shared types and constants for the medication reminder tile.
package medication_reminder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      ALERT  = 2'd2,
      SNOOZE = 2'd3
   } state_t;

   localparam int UO_ALARM     = 0;
   localparam int UO_BUZZER    = 1;
   localparam int UO_COUNTING  = 2;
   localparam int UO_MISSED    = 3;
   localparam int UO_TAKEN_LSB = 4;

   localparam int UI_LOAD   = 0;
   localparam int UI_ACK    = 1;
   localparam int UI_SNOOZE = 2;
   localparam int UI_STOP   = 3;

   localparam logic [3:0] CNT_MAX = 4'hF;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == CNT_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/medication_reminder_tick_gen.sv
// Prescaler: one-cycle tick every DIV enabled cycles.
import medication_reminder_pkg::*;

module rm_tick_gen #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;
   logic         at_last;

   assign at_last = (cnt == LAST);
   assign tick    = en & ~clr & at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_last ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/medication_reminder.sv
// Medication dose reminder tile: countdown, alert, taken/missed logging.
// Optional snooze state enabled by defining MED_REMINDER_SNOOZE_EN.
import medication_reminder_pkg::*;

module medication_reminder #(
   parameter int TICK_DIV      = 1000,
   parameter int ALERT_TIMEOUT = 16,
   parameter int SNOOZE_TICKS  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] key_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [7:0] AT_LAST = 8'(ALERT_TIMEOUT - 1);

   state_t     state;
   logic [7:0] interval;
   logic [7:0] remaining;
   logic [7:0] alert_cnt;
   logic [3:0] taken_cnt;
   logic [3:0] missed_cnt;
   logic       blink;
   logic [3:0] ui_q;

   logic [3:0] rise;
   logic       stop_e;
   logic       load_e;
   logic       ack_e;
   logic       snooze_e;
   logic       tick;
   logic       tick_en;

   assign rise     = ena ? (ui_in[3:0] & ~ui_q) : 4'b0000;
   assign stop_e   = rise[UI_STOP];
   assign load_e   = rise[UI_LOAD] & (key_in != 8'd0);
   assign ack_e    = rise[UI_ACK] &
                     ((state == ALERT) | (state == SNOOZE));
   assign snooze_e = rise[UI_SNOOZE] & (state == ALERT);
   assign tick_en  = ena & (state != IDLE);

   rm_tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tick_en),
      .clr   (stop_e | load_e),
      .tick  (tick)
   );

`ifdef MED_REMINDER_SNOOZE_EN
   localparam logic [7:0] ST_LAST = 8'(SNOOZE_TICKS - 1);
   logic [7:0] snooze_cnt;
   logic       unused;
   assign unused = &{1'b0, ui_in[7:4], uio_in};
`else
   logic       unused;
   assign unused = &{1'b0, ui_in[7:4], uio_in, snooze_e};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         interval   <= 8'd0;
         remaining  <= 8'd0;
         alert_cnt  <= 8'd0;
         taken_cnt  <= 4'd0;
         missed_cnt <= 4'd0;
         blink      <= 1'b0;
         ui_q       <= 4'd0;
`ifdef MED_REMINDER_SNOOZE_EN
         snooze_cnt <= 8'd0;
`endif
      end else if (ena) begin
         ui_q <= ui_in[3:0];
         if (stop_e) begin
            state     <= IDLE;
            remaining <= 8'd0;
         end else if (load_e) begin
            interval  <= key_in;
            remaining <= key_in;
            state     <= COUNT;
         end else if (ack_e) begin
            taken_cnt <= sat_inc(taken_cnt);
            remaining <= interval;
            state     <= COUNT;
`ifdef MED_REMINDER_SNOOZE_EN
         end else if (snooze_e) begin
            state      <= SNOOZE;
            snooze_cnt <= 8'd0;
`endif
         end else if (tick) begin
            unique case (state)
               COUNT: begin
                  if (remaining == 8'd1) begin
                     state     <= ALERT;
                     remaining <= 8'd0;
                     alert_cnt <= 8'd0;
                  end else begin
                     remaining <= remaining - 8'd1;
                  end
               end
               ALERT: begin
                  blink     <= ~blink;
                  alert_cnt <= alert_cnt + 8'd1;
                  // timeout logs a miss and rearms the countdown
                  if (alert_cnt == AT_LAST) begin
                     missed_cnt <= sat_inc(missed_cnt);
                     remaining  <= interval;
                     state      <= COUNT;
                  end
               end
`ifdef MED_REMINDER_SNOOZE_EN
               SNOOZE: begin
                  snooze_cnt <= snooze_cnt + 8'd1;
                  if (snooze_cnt == ST_LAST) begin
                     state     <= ALERT;
                     alert_cnt <= 8'd0;
                  end
               end
`endif
               default: begin
               end
            endcase
         end
      end
   end

   always_comb begin
      uo_out                 = 8'h00;
      uo_out[UO_ALARM]       = (state == ALERT);
      uo_out[UO_BUZZER]      = (state == ALERT) & blink;
      uo_out[UO_COUNTING]    = (state == COUNT);
      uo_out[UO_MISSED]      = (missed_cnt != 4'd0);
      uo_out[UO_TAKEN_LSB+:4] = taken_cnt;
   end

   assign uio_out = remaining;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_medication_reminder.sv
// Self-checking bench: directed table, corner sequences, random vs model.
module tb_medication_reminder;

   localparam int TD = 4;
   localparam int AT = 3;
   localparam int ST = 2;
`ifdef MED_REMINDER_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] key_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   wire  [7:0] uo_out;
   wire  [7:0] uio_out;
   wire  [7:0] uio_oe;

   always #5 clk = ~clk;

   medication_reminder #(
      .TICK_DIV      (TD),
      .ALERT_TIMEOUT (AT),
      .SNOOZE_TICKS  (ST)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .key_in  (key_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   // Reference model: modes 0 idle, 1 counting, 2 alerting, 3 snoozed
   int         m_mode, m_int, m_rem, m_pre, m_acnt, m_scnt;
   int         m_taken, m_missed;
   bit         m_blink;
   logic [3:0] m_prev;

   function void m_reset();
      m_mode = 0; m_int = 0; m_rem = 0; m_pre = 0;
      m_acnt = 0; m_scnt = 0; m_taken = 0; m_missed = 0;
      m_blink = 0; m_prev = 4'd0;
   endfunction

   function void m_step(input logic e, input logic [7:0] ui,
                        input logic [7:0] key);
      logic [3:0] r;
      bit tk;
      if (!e) return;
      r = ui[3:0] & ~m_prev;
      m_prev = ui[3:0];
      tk = (m_mode != 0) && (m_pre == TD - 1);
      if (m_mode != 0) m_pre = (m_pre + 1) % TD;
      if (r[3]) begin
         m_mode = 0; m_rem = 0; m_pre = 0;
      end else if (r[0] && key != 0) begin
         m_int = key; m_rem = key; m_mode = 1; m_pre = 0;
      end else if (r[1] && m_mode >= 2) begin
         if (m_taken < 15) m_taken++;
         m_rem = m_int; m_mode = 1;
      end else if (SNZ && r[2] && m_mode == 2) begin
         m_mode = 3; m_scnt = 0;
      end else if (tk) begin
         if (m_mode == 1) begin
            m_rem--;
            if (m_rem == 0) begin m_mode = 2; m_acnt = 0; end
         end else if (m_mode == 2) begin
            m_blink = ~m_blink;
            m_acnt++;
            if (m_acnt == AT) begin
               if (m_missed < 15) m_missed++;
               m_rem = m_int; m_mode = 1;
            end
         end else if (m_mode == 3) begin
            m_scnt++;
            if (m_scnt == ST) begin m_mode = 2; m_acnt = 0; end
         end
      end
   endfunction

   function automatic logic [7:0] m_uo();
      logic [7:0] r;
      r[7:4] = 4'(m_taken);
      r[3]   = (m_missed != 0);
      r[2]   = (m_mode == 1);
      r[1]   = (m_mode == 2) && m_blink;
      r[0]   = (m_mode == 2);
      return r;
   endfunction

   task automatic cyc(input logic e, input logic [7:0] ui,
                      input logic [7:0] key);
      ena = e; ui_in = ui; key_in = key;
      @(posedge clk);
      m_step(e, ui, key);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; key_in = 8'h00;
      m_reset();
      @(posedge clk);
      #1;
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_oe", uio_oe, 8'hFF);
      rst_n = 1'b1;
   endtask

   task automatic wait_alarm(input string name, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         cyc(1'b1, 8'h00, 8'h00);
         if (uo_out[0]) begin seen = 1; break; end
      end
      check(name, {7'd0, seen}, 8'h01);
   endtask

   typedef struct {
      string      name;
      logic       en;
      logic [7:0] ui;
      logic [7:0] key;
      int         n;
      logic [7:0] uo;
      logic [7:0] uio;
   } vec_t;

   vec_t vt[$];

   function void add(input string nm, input logic en, input logic [7:0] ui,
                     input logic [7:0] key, input int n,
                     input logic [7:0] uo, input logic [7:0] uio);
      vec_t v;
      v.name = nm; v.en = en; v.ui = ui; v.key = key;
      v.n = n; v.uo = uo; v.uio = uio;
      vt.push_back(v);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      add("idle",   1, 8'h00, 8'd0, 1, 8'h00, 8'd0);
      add("load3",  1, 8'h01, 8'd3, 1, 8'h04, 8'd3);
      add("cnt2",   1, 8'h00, 8'd0, 4, 8'h04, 8'd2);
      add("cnt1",   1, 8'h00, 8'd0, 4, 8'h04, 8'd1);
      add("alert",  1, 8'h00, 8'd0, 4, 8'h01, 8'd0);
      add("blink",  1, 8'h00, 8'd0, 4, 8'h03, 8'd0);
      add("ack",    1, 8'h02, 8'd0, 1, 8'h14, 8'd3);
      add("ack_c2", 1, 8'h00, 8'd0, 3, 8'h14, 8'd2);
      add("ack_c1", 1, 8'h00, 8'd0, 4, 8'h14, 8'd1);
      add("alert2", 1, 8'h00, 8'd0, 4, 8'h13, 8'd0);
      add("acnt1",  1, 8'h00, 8'd0, 4, 8'h11, 8'd0);
      add("acnt2",  1, 8'h00, 8'd0, 4, 8'h13, 8'd0);
      add("missed", 1, 8'h00, 8'd0, 4, 8'h1C, 8'd3);
      add("stop",   1, 8'h08, 8'd0, 1, 8'h18, 8'd0);
      add("load0",  1, 8'h01, 8'd0, 1, 8'h18, 8'd0);
      add("idle2",  1, 8'h00, 8'd0, 2, 8'h18, 8'd0);
      add("load5",  1, 8'h01, 8'd5, 1, 8'h1C, 8'd5);
      add("pre2",   1, 8'h00, 8'd0, 2, 8'h1C, 8'd5);
      add("frozen", 0, 8'h01, 8'd9, 7, 8'h1C, 8'd5);
      add("thaw",   1, 8'h00, 8'd0, 1, 8'h1C, 8'd5);
      add("tick4",  1, 8'h00, 8'd0, 1, 8'h1C, 8'd4);

      do_reset();
      foreach (vt[i]) begin
         for (int k = 0; k < vt[i].n; k++)
            cyc(vt[i].en, vt[i].ui, vt[i].key);
         check({vt[i].name, "_uo"}, uo_out, vt[i].uo);
         check({vt[i].name, "_uio"}, uio_out, vt[i].uio);
      end

      // stop and ack together: stop wins, taken count untouched
      wait_alarm("wait_alarm1", 40);
      cyc(1'b1, 8'h0A, 8'h00);
      check("stop_ack_uo", uo_out, 8'h18);
      check("stop_ack_uio", uio_out, 8'h00);
      cyc(1'b1, 8'h00, 8'h00);

      // snooze silences alarm for two ticks only when built in
      cyc(1'b1, 8'h01, 8'h01);
      wait_alarm("wait_alarm2", 12);
      cyc(1'b1, 8'h04, 8'h00);
      check("snooze_now", {7'd0, uo_out[0]}, {7'd0, ~SNZ});
      for (int k = 0; k < 4; k++) cyc(1'b1, 8'h00, 8'h00);
      check("snooze_mid", {7'd0, uo_out[0]}, {7'd0, ~SNZ});
      for (int k = 0; k < 3; k++) cyc(1'b1, 8'h00, 8'h00);
      check("snooze_end", {7'd0, uo_out[0]}, 8'h01);

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] ui;
         logic       e;
         ui[0] = ($urandom_range(0, 99) < 4);
         ui[1] = ($urandom_range(0, 99) < 8);
         ui[2] = ($urandom_range(0, 99) < 8);
         ui[3] = ($urandom_range(0, 99) < 1);
         ui[7:4] = 4'($urandom);
         e = ($urandom_range(0, 15) != 0);
         cyc(e, ui, 8'($urandom_range(0, 5)));
         check($sformatf("rnd%0d_uo", c), uo_out, m_uo());
         check($sformatf("rnd%0d_uio", c), uio_out, 8'(m_rem));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
